// File: rtl/multicycle_sequencer_if.sv
// Control/status bundle between the multi-cycle sequencer and the ASIP datapath/memory.
interface multicycle_sequencer_if #(
  parameter int unsigned CNT_W = 16
);
  logic             start;
  logic [2:0]       opcode;
  logic [1:0]       funct;
  logic             zero_flag;
  logic             mem_ready;
  logic             mem_req;
  logic             mem_we;
  logic             mem_addr_sel;
  logic             ir_en;
  logic             pc_en;
  logic             pc_src;
  logic             rf_we;
  logic             flags_we;
  logic             wd_sel;
  logic             opb_sel;
  logic             alu_func;
  logic [1:0]       ext_sel;
  logic             rb_sel;
  logic             busy;
  logic             err;
  logic [CNT_W-1:0] instr_count;

  // Sequencer side
  modport master (
    input  start, opcode, funct, zero_flag, mem_ready,
    output mem_req, mem_we, mem_addr_sel, ir_en, pc_en, pc_src, rf_we, flags_we,
           wd_sel, opb_sel, alu_func, ext_sel, rb_sel, busy, err, instr_count
  );

  // Datapath / memory side
  modport slave (
    output start, opcode, funct, zero_flag, mem_ready,
    input  mem_req, mem_we, mem_addr_sel, ir_en, pc_en, pc_src, rf_we, flags_we,
           wd_sel, opb_sel, alu_func, ext_sel, rb_sel, busy, err, instr_count
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM sharing one single-port memory between fetch and LDR/STR.
module multicycle_sequencer #(
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned CNT_W    = 16
) (
  input logic                    clk,
  input logic                    rst,
  multicycle_sequencer_if.master bus
);
  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

  localparam logic [2:0] OP_ALU = 3'b000;
  localparam logic [2:0] OP_CMP = 3'b001;
  localparam logic [2:0] OP_LDR = 3'b010;
  localparam logic [2:0] OP_STR = 3'b011;
  localparam logic [2:0] OP_JEQ = 3'b100;
  localparam logic [2:0] OP_JNE = 3'b101;
  localparam logic [2:0] OP_JMP = 3'b110;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    ERR    = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q;
  logic [CNT_W-1:0]    count_q;
  logic [2:0]          op_q;
  logic                opb_q, alu_q, rb_q;
  logic [1:0]          ext_q;
  logic                opb_d, alu_d, rb_d;
  logic [1:0]          ext_d;
  logic                retire, stall, taken;
  logic                mem_req, mem_we, mem_addr_sel, ir_en, pc_en, pc_src;
  logic                rf_we, flags_we, wd_sel, err;

  // Immediate/operand decode of the live IR fields; illegal CMP decodes as NOP
  always_comb begin
    ext_d = 2'b10;
    opb_d = 1'b0;
    alu_d = 1'b0;
    rb_d  = 1'b0;
    case (bus.opcode)
      OP_ALU: begin
        ext_d = bus.funct[0] ? 2'b00 : 2'b11;
        opb_d = bus.funct[0];
        alu_d = bus.funct[1];
      end
      OP_CMP: begin
        if (bus.funct[1]) begin
          ext_d = bus.funct[0] ? 2'b00 : 2'b11;
          opb_d = bus.funct[0];
          alu_d = 1'b1;
        end
      end
      OP_LDR: begin
        ext_d = 2'b01;
        opb_d = 1'b1;
      end
      OP_STR: begin
        ext_d = 2'b01;
        opb_d = 1'b1;
        rb_d  = 1'b1;
      end
      default: ;
    endcase
  end

  // Branch condition evaluated in DECODE
  always_comb begin
    taken = (bus.opcode == OP_JMP) ||
            ((bus.opcode == OP_JEQ) &&  bus.zero_flag) ||
            ((bus.opcode == OP_JNE) && !bus.zero_flag);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; retirement redirects to FETCH or IDLE depending on start
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    stall   = 1'b0;
    case (state_q)
      IDLE:   if (bus.start) state_d = FETCH;
      FETCH: begin
        if (bus.mem_ready) state_d = DECODE;
        else begin
          stall = 1'b1;
          if (wait_q == WAIT_W'(MAX_WAIT)) state_d = ERR;
        end
      end
      DECODE: begin
        case (bus.opcode)
          OP_ALU, OP_LDR, OP_STR: state_d = EXEC;
          OP_CMP: begin
            if (bus.funct[1]) state_d = EXEC;
            else              retire  = 1'b1;
          end
          default: retire = 1'b1;
        endcase
      end
      EXEC: begin
        case (op_q)
          OP_ALU:         state_d = WB;
          OP_LDR, OP_STR: state_d = MEM;
          default:        retire  = 1'b1;
        endcase
      end
      MEM: begin
        if (bus.mem_ready) begin
          if (op_q == OP_STR) retire  = 1'b1;
          else                state_d = WB;
        end else begin
          stall = 1'b1;
          if (wait_q == WAIT_W'(MAX_WAIT)) state_d = ERR;
        end
      end
      WB:      retire  = 1'b1;
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase
    if (retire) state_d = bus.start ? FETCH : IDLE;
  end

  // Per-cycle strobes from state, registered decode fields and mem_ready
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_en        = 1'b0;
    pc_en        = 1'b0;
    pc_src       = 1'b0;
    rf_we        = 1'b0;
    flags_we     = 1'b0;
    wd_sel       = 1'b0;
    err          = 1'b0;
    case (state_q)
      FETCH: begin
        mem_req = 1'b1;
        ir_en   = bus.mem_ready;
        pc_en   = bus.mem_ready;
      end
      DECODE: begin
        pc_en  = taken;
        pc_src = taken;
      end
      EXEC:   flags_we = (op_q == OP_CMP);
      MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (op_q == OP_STR);
      end
      WB: begin
        rf_we  = 1'b1;
        wd_sel = (op_q == OP_LDR);
      end
      ERR:     err = 1'b1;
      default: ;
    endcase
  end

  // Memory wait counter: counts stalled cycles, clears otherwise
  always_ff @(posedge clk) begin
    if (rst)        wait_q <= '0;
    else if (stall) wait_q <= wait_q + WAIT_W'(1);
    else            wait_q <= '0;
  end

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk) begin
    if (rst)         count_q <= '0;
    else if (retire) count_q <= count_q + CNT_W'(1);
  end

  // Decode fields captured in DECODE and held until the next DECODE
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q  <= '0;
      ext_q <= '0;
      opb_q <= 1'b0;
      alu_q <= 1'b0;
      rb_q  <= 1'b0;
    end else if (state_q == DECODE) begin
      op_q  <= bus.opcode;
      ext_q <= ext_d;
      opb_q <= opb_d;
      alu_q <= alu_d;
      rb_q  <= rb_d;
    end
  end

  assign bus.mem_req      = mem_req;
  assign bus.mem_we       = mem_we;
  assign bus.mem_addr_sel = mem_addr_sel;
  assign bus.ir_en        = ir_en;
  assign bus.pc_en        = pc_en;
  assign bus.pc_src       = pc_src;
  assign bus.rf_we        = rf_we;
  assign bus.flags_we     = flags_we;
  assign bus.wd_sel       = wd_sel;
  assign bus.opb_sel      = opb_q;
  assign bus.alu_func     = alu_q;
  assign bus.ext_sel      = ext_q;
  assign bus.rb_sel       = rb_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.err          = err;
  assign bus.instr_count  = count_q;
endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench: per-cycle expected outputs queued by stimulus, checked by a monitor.
module tb_multicycle_sequencer;
  localparam logic [15:0] S_REQ  = 16'h8000;
  localparam logic [15:0] S_WE   = 16'h4000;
  localparam logic [15:0] S_ASEL = 16'h2000;
  localparam logic [15:0] S_IR   = 16'h1000;
  localparam logic [15:0] S_PC   = 16'h0800;
  localparam logic [15:0] S_PSRC = 16'h0400;
  localparam logic [15:0] S_RFWE = 16'h0200;
  localparam logic [15:0] S_FLW  = 16'h0100;
  localparam logic [15:0] S_WD   = 16'h0080;
  localparam logic [15:0] S_BUSY = 16'h0002;
  localparam logic [15:0] S_ERR  = 16'h0001;
  localparam logic [15:0] FT     = S_REQ | S_IR | S_PC | S_BUSY;
  // decode field images: [6]opb_sel [5]alu_func [4:3]ext_sel [2]rb_sel
  localparam logic [15:0] D_ADD   = 16'h0018;
  localparam logic [15:0] D_SUBI  = 16'h0060;
  localparam logic [15:0] D_CMP10 = 16'h0038;
  localparam logic [15:0] D_LDR   = 16'h0048;
  localparam logic [15:0] D_STR   = 16'h004C;
  localparam logic [15:0] D_BR    = 16'h0010;

  typedef struct {
    string          name;
    logic [15:0]    o;
    int unsigned    cnt;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, zero_flag, mem_ready;
  logic [2:0] opcode;
  logic [1:0] funct;

  exp_t q[$];
  exp_t e;
  int   tests = 0;
  int   fails = 0;

  multicycle_sequencer_if #(.CNT_W(16)) b1 ();
  multicycle_sequencer_if #(.CNT_W(2))  b2 ();

  assign b1.start = start;     assign b2.start = start;
  assign b1.opcode = opcode;   assign b2.opcode = opcode;
  assign b1.funct = funct;     assign b2.funct = funct;
  assign b1.zero_flag = zero_flag; assign b2.zero_flag = zero_flag;
  assign b1.mem_ready = mem_ready; assign b2.mem_ready = mem_ready;

  multicycle_sequencer #(.MAX_WAIT(15), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(b1));
  multicycle_sequencer #(.MAX_WAIT(15), .CNT_W(2))  dut_w2 (.clk(clk), .rst(rst), .bus(b2));

  wire [15:0] o1 = {b1.mem_req, b1.mem_we, b1.mem_addr_sel, b1.ir_en, b1.pc_en, b1.pc_src,
                    b1.rf_we, b1.flags_we, b1.wd_sel, b1.opb_sel, b1.alu_func, b1.ext_sel,
                    b1.rb_sel, b1.busy, b1.err};
  wire [15:0] o2 = {b2.mem_req, b2.mem_we, b2.mem_addr_sel, b2.ir_en, b2.pc_en, b2.pc_src,
                    b2.rf_we, b2.flags_we, b2.wd_sel, b2.opb_sel, b2.alu_func, b2.ext_sel,
                    b2.rb_sel, b2.busy, b2.err};

  // Monitor: each queued cycle expectation is compared away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        tests++;
        if (o1 !== e.o) begin
          fails++;
          $display("FAIL %s outputs: got %h expected %h", e.name, o1, e.o);
        end
        tests++;
        if (b1.instr_count !== 16'(e.cnt)) begin
          fails++;
          $display("FAIL %s instr_count: got %0d expected %0d", e.name, b1.instr_count, e.cnt);
        end
        tests++;
        if ({o2, b2.instr_count} !== {e.o, 2'(e.cnt % 4)}) begin
          fails++;
          $display("FAIL %s cnt_w2: got %h/%0d expected %h/%0d", e.name, o2, b2.instr_count,
                   e.o, e.cnt % 4);
        end
      end
    end
  end

  task automatic set_instr(input logic [2:0] op, input logic [1:0] fn, input logic zf);
    opcode    = op;
    funct     = fn;
    zero_flag = zf;
  endtask

  task automatic step(input logic s, input logic rdy, input logic r, input string nm,
                      input logic [15:0] eo, input int unsigned ec);
    start     = s;
    mem_ready = rdy;
    rst       = r;
    q.push_back('{nm, eo, ec});
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    mem_ready = 1'b0;
    set_instr(3'b000, 2'b00, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    step(0, 0, 1, "reset", 16'h0, 0);

    // ADD, zero wait
    step(1, 1, 0, "add_idle",   16'h0,                  0);
    step(1, 1, 0, "add_fetch",  FT,                     0);
    step(1, 1, 0, "add_decode", S_BUSY,                 0);
    step(1, 1, 0, "add_exec",   S_BUSY | D_ADD,         0);
    step(1, 1, 0, "add_wb",     S_RFWE | S_BUSY | D_ADD, 0);

    // LDR with 3 wait cycles in MEM
    set_instr(3'b010, 2'b00, 1'b0);
    step(1, 1, 0, "ldr_fetch",  FT | D_ADD,     1);
    step(1, 1, 0, "ldr_decode", S_BUSY | D_ADD, 1);
    step(1, 1, 0, "ldr_exec",   S_BUSY | D_LDR, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, "ldr_mem_wait", S_REQ | S_ASEL | S_BUSY | D_LDR, 1);
    step(1, 1, 0, "ldr_mem_done", S_REQ | S_ASEL | S_BUSY | D_LDR, 1);
    step(1, 1, 0, "ldr_wb", S_RFWE | S_WD | S_BUSY | D_LDR, 1);

    // CMP 001/10
    set_instr(3'b001, 2'b10, 1'b0);
    step(1, 1, 0, "cmp_fetch",  FT | D_LDR,                2);
    step(1, 1, 0, "cmp_decode", S_BUSY | D_LDR,            2);
    step(1, 1, 0, "cmp_exec",   S_FLW | S_BUSY | D_CMP10,  2);

    // JEQ taken, JNE not taken (zero_flag=1)
    set_instr(3'b100, 2'b00, 1'b1);
    step(1, 1, 0, "jeq_fetch",  FT | D_CMP10, 3);
    step(1, 1, 0, "jeq_decode", S_PC | S_PSRC | S_BUSY | D_CMP10, 3);
    set_instr(3'b101, 2'b00, 1'b1);
    step(1, 1, 0, "jne_fetch",  FT | D_BR,     4);
    step(1, 1, 0, "jne_decode", S_BUSY | D_BR, 4);

    // SUBI with start dropped mid-instruction
    set_instr(3'b000, 2'b11, 1'b0);
    step(1, 1, 0, "subi_fetch",  FT | D_BR,               5);
    step(1, 1, 0, "subi_decode", S_BUSY | D_BR,           5);
    step(0, 1, 0, "subi_exec",   S_BUSY | D_SUBI,         5);
    step(0, 1, 0, "subi_wb",     S_RFWE | S_BUSY | D_SUBI, 5);
    step(0, 1, 0, "idle_after_subi",  D_SUBI, 6);
    step(0, 1, 0, "idle_hold",        D_SUBI, 6);

    // Illegal CMP 001/00 retires from DECODE like a NOP
    set_instr(3'b001, 2'b00, 1'b0);
    step(1, 1, 0, "ill_idle",   D_SUBI,          6);
    step(1, 1, 0, "ill_fetch",  FT | D_SUBI,     6);
    step(1, 1, 0, "ill_decode", S_BUSY | D_SUBI, 6);

    // JMP always taken
    set_instr(3'b110, 2'b00, 1'b0);
    step(1, 1, 0, "jmp_fetch",  FT | D_BR, 7);
    step(1, 1, 0, "jmp_decode", S_PC | S_PSRC | S_BUSY | D_BR, 7);

    // STR interrupted by reset in MEM
    set_instr(3'b011, 2'b00, 1'b0);
    step(1, 1, 0, "str_fetch",  FT | D_BR,      8);
    step(1, 1, 0, "str_decode", S_BUSY | D_BR,  8);
    step(1, 1, 0, "str_exec",   S_BUSY | D_STR, 8);
    step(1, 0, 0, "str_mem_wait", S_REQ | S_WE | S_ASEL | S_BUSY | D_STR, 8);
    step(1, 0, 1, "str_mem_rst",  S_REQ | S_WE | S_ASEL | S_BUSY | D_STR, 8);
    step(0, 0, 0, "after_rst", 16'h0, 0);

    // Complete STR, zero wait
    step(1, 1, 0, "str2_idle",   16'h0,          0);
    step(1, 1, 0, "str2_fetch",  FT,             0);
    step(1, 1, 0, "str2_decode", S_BUSY,         0);
    step(1, 1, 0, "str2_exec",   S_BUSY | D_STR, 0);
    step(1, 1, 0, "str2_mem",    S_REQ | S_WE | S_ASEL | S_BUSY | D_STR, 0);

    // Fetch timeout: 16 stalled FETCH cycles then ERR, sticky until rst
    set_instr(3'b111, 2'b00, 1'b0);
    for (int i = 0; i < 16; i++) step(1, 0, 0, "timeout_fetch", S_REQ | S_BUSY | D_STR, 1);
    for (int i = 0; i < 3; i++) step(1, 1, 0, "err_hold", S_ERR | S_BUSY | D_STR, 1);
    step(1, 1, 1, "err_rst_cycle", S_ERR | S_BUSY | D_STR, 1);
    step(0, 1, 0, "err_cleared", 16'h0, 0);

    // mem_ready on the last allowed FETCH cycle wins over the timeout
    step(1, 1, 0, "nop_idle", 16'h0, 0);
    for (int i = 0; i < 15; i++) step(1, 0, 0, "limit_fetch_wait", S_REQ | S_BUSY, 0);
    step(1, 1, 0, "limit_fetch_ready", FT, 0);
    step(0, 1, 0, "nop_decode", S_BUSY, 0);
    step(0, 1, 0, "idle_after_nop", D_BR, 1);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle control FSM for the ASIP datapath; replaces single-cycle operation so one shared single-port memory serves both instruction fetch and LDR/STR.
- Decodes the 3-bit opcode / 2-bit funct ISA (ADD/ADDI/SUB/SUBI, CMP, LDR, STR, JEQ/JNE/JMP, NOP).
- Drives per-cycle enables, the memory request handshake, a memory-wait timeout and a retired-instruction counter.

Parameters:
- MAX_WAIT, 15, maximum consecutive cycles with mem_req=1 and mem_ready=0 before entering ERR.
- CNT_W, 16, width of instr_count.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  run enable; sampled in IDLE and at instruction boundaries.
- opcode  in  3  instruction opcode from IR.
- funct  in  2  instruction function field from IR.
- zero_flag  in  1  registered zero flag from the last CMP.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request, held until mem_ready.
- mem_we  out  1  write request (STR only).
- mem_addr_sel  out  1  0 = PC, 1 = ALU result.
- ir_en  out  1  load IR.
- pc_en  out  1  load PC.
- pc_src  out  1  0 = PC+1, 1 = branch target.
- rf_we  out  1  register-file write.
- flags_we  out  1  flag register write.
- wd_sel  out  1  0 = ALU result, 1 = memory data.
- opb_sel  out  1  0 = register, 1 = extended immediate.
- alu_func  out  1  0 = add, 1 = sub.
- ext_sel  out  2  immediate extension type.
- rb_sel  out  1  second read-register select.
- busy  out  1  state is not IDLE.
- err  out  1  memory timeout occurred.
- instr_count  out  CNT_W  retired instructions.

Behaviour:
- Reset: state=IDLE, wait counter=0, instr_count=0, decode fields all 0. Every output is 0 from the first edge with rst=1, including mid-instruction (an in-flight memory request is dropped).
- Strobes are combinational from state, the registered decode fields and mem_ready.
- Decode fields (opb_sel, alu_func, ext_sel, rb_sel) are registered in DECODE and held until the next DECODE.

State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, ERR=6.
- IDLE: if start=1, go to FETCH.
- FETCH: mem_req=1, mem_addr_sel=0. When mem_ready=1 in the same cycle: ir_en=1, pc_en=1, pc_src=0, then go to DECODE. Otherwise stay.
- DECODE: latch the decode fields, then:
  - opcode 000 or 001: go to EXEC.
  - LDR (010), STR (011): go to EXEC.
  - Branch, same cycle:
    - JEQ (100) is taken if zero_flag=1.
    - JNE (101) is taken if zero_flag=0.
    - JMP (110) is always taken.
    - If taken, pc_en=1 and pc_src=1.
    - The branch retires and goes to FETCH.
  - NOP (111): retires and goes to FETCH.
  - CMP with funct 00 or 01 is illegal: treated as NOP.
- EXEC:
  - Arithmetic (000): go to WB.
  - CMP: flags_we=1, retires, goes to FETCH.
  - LDR/STR: go to MEM.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=1 for STR. On mem_ready=1: LDR goes to WB; STR retires and goes to FETCH.
- WB: rf_we=1; wd_sel=1 for LDR, else 0. Retires, goes to FETCH.
- Instruction boundary: every retirement increments instr_count (wraps at 2^CNT_W, no saturation). If start=0 on a retirement cycle, go to IDLE instead of FETCH.
- ERR: all strobes 0, err=1, busy=1. Held until rst.

Decode values (ext_sel / opb_sel / alu_func; rb_sel=0 unless stated):
- ADD 000/00: 11 / 0 / 0.
- ADDI 000/01: 00 / 1 / 0.
- SUB 000/10: 11 / 0 / 1.
- SUBI 000/11: 00 / 1 / 1.
- CMP 001/10: 11 / 0 / 1.
- CMP 001/11: 00 / 1 / 1.
- LDR: 01 / 1 / 0.
- STR: 01 / 1 / 0, with rb_sel=1.
- Branches and NOP: 10 / 0 / 0.

Memory handshake and timeout:
- A transfer completes in the cycle where mem_req=1 and mem_ready=1.
- mem_ready is ignored when mem_req=0.
- The wait counter clears on every completed transfer and on entry to FETCH/MEM, and increments on each stalled cycle.
- When the counter reaches MAX_WAIT, the next state is ERR instead of staying.
- A mem_ready arriving in that same cycle wins: the transfer completes, no error.

Latency with zero memory wait:
- ALU ops: 4 cycles.
- CMP: 3 cycles.
- LDR: 5 cycles.
- STR: 4 cycles.
- Branch and NOP: 2 cycles.
- Each memory wait cycle adds 1.

Test Plan:
- rst, then start=1, ADD (000/00), mem_ready tied 1 → states 1,2,3,5,1. rf_we high only in WB, with ext_sel=11, opb_sel=0, alu_func=0. instr_count=1 after 4 cycles.
- LDR with mem_ready delayed 3 cycles in MEM → mem_req and mem_addr_sel=1 held 4 cycles; WB has rf_we=1, wd_sel=1. Total 8 cycles.
- CMP 001/10 sets flags, then JEQ with zero_flag=1 → pc_src=1, pc_en=1 in DECODE. JNE with zero_flag=1 → pc_en=0 in DECODE, falls through.
- mem_ready held 0 in FETCH with MAX_WAIT=15 → ERR after 16 FETCH cycles, err=1, mem_req=0. Only rst clears it.
- rst asserted in MEM during STR → next cycle all outputs 0, IDLE, instr_count=0, no mem_we.
- start dropped during a SUBI → instruction completes, instr_count increments, FSM goes to IDLE with busy=0. With CNT_W=2, 4 retirements wrap instr_count to 0.
